// File: rtl/alu_muldiv_unit_if.sv
// alu_muldiv_unit_if: request/response bundle between the issue logic and the multiply/divide unit
interface alu_muldiv_unit_if #(parameter int XLEN = 32);
    logic            Start_i;
    logic [2:0]      Funct3_i;
    logic [XLEN-1:0] Operand_a_i;
    logic [XLEN-1:0] Operand_b_i;
    logic            Flush_i;
    logic            Busy_o;
    logic            Done_o;
    logic [XLEN-1:0] Result_o;
    modport master (
        output Start_i, Funct3_i, Operand_a_i, Operand_b_i, Flush_i,
        input  Busy_o, Done_o, Result_o
    );
    modport slave (
        input  Start_i, Funct3_i, Operand_a_i, Operand_b_i, Flush_i,
        output Busy_o, Done_o, Result_o
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on operand magnitudes
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic                Clk_i,
    input logic                Rstn_i,
    alu_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    state_t            state;
    logic [2:0]        f3;
    logic [XLEN-1:0]   mag_a, mag_b, result;
    logic              neg, busy, done;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2:0]        f;
    logic [XLEN-1:0]   a, b, abs_a, abs_b, special_res, quot, rem, dsel, dres, fix_res;
    logic              sa, sb, a_neg, b_neg, neg_n, div_zero, ovf;
    logic [XLEN:0]     mul_sum, div_part, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    assign f = bus.Funct3_i;
    assign a = bus.Operand_a_i;
    assign b = bus.Operand_b_i;
    // launch decode: operand signedness, magnitudes, sign of the final result and special cases
    always_comb begin
        sb          = (f == 3'b001) | (f[2] & ~f[0]);
        sa          = sb | (f == 3'b010);
        a_neg       = sa & a[XLEN-1];
        b_neg       = sb & b[XLEN-1];
        abs_a       = a_neg ? -a : a;
        abs_b       = b_neg ? -b : b;
        neg_n       = (f[2] & f[1]) ? a_neg : a_neg ^ b_neg;
        div_zero    = f[2] & (b == '0);
        ovf         = f[2] & ~f[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        special_res = div_zero ? (f[1] ? a : '1) : (f[1] ? '0 : a);
    end
    // one radix-2 step: shift-add for multiply, restoring trial subtraction for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_a};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        div_part = acc[2*XLEN-1:XLEN-1];
        div_diff = div_part - {1'b0, mag_b};
        div_next = {div_diff[XLEN] ? div_part[XLEN-1:0] : div_diff[XLEN-1:0], acc[XLEN-2:0], ~div_diff[XLEN]};
    end
    // final selection and sign fix-up; products are negated over the full double width
    always_comb begin
        prod    = neg ? -acc : acc;
        quot    = acc[XLEN-1:0];
        rem     = acc[2*XLEN-1:XLEN];
        dsel    = f3[1] ? rem : quot;
        dres    = neg ? -dsel : dsel;
        fix_res = f3[2] ? dres : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    // control FSM with registered busy/done/result; flush abandons work without touching result
    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            state  <= IDLE;
            f3     <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (bus.Flush_i) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start_i) begin
                        f3    <= f;
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= neg_n;
                        cnt   <= CW'(XLEN-1);
                        acc   <= {{XLEN{1'b0}}, f[2] ? abs_a : abs_b};
                        busy  <= 1'b1;
                        if (div_zero | ovf) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    acc <= f3[2] ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
    assign bus.Busy_o   = busy;
    assign bus.Done_o   = done;
    assign bus.Result_o = result;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed vectors for the multiply/divide unit with hand-computed results
module tb_alu_muldiv_unit;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tot = 0;
    int   n_pass = 0;
    logic [31:0] res;
    int   lat;
    logic busy_ok;
    logic seen;
    always #5 clk = ~clk;
    alu_muldiv_unit_if #(.XLEN(32)) bus ();
    alu_muldiv_unit #(.XLEN(32)) dut (.Clk_i(clk), .Rstn_i(rstn), .bus(bus));
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int poke,
                          output logic [31:0] r, output int l, output logic bok);
        @(negedge clk);
        bus.Start_i = 1'b1;
        bus.Funct3_i = f;
        bus.Operand_a_i = a;
        bus.Operand_b_i = b;
        @(posedge clk);
        #1 bus.Start_i = 1'b0;
        l = -1;
        r = 'x;
        bok = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1 bus.Start_i = 1'b0;
            end
            if (!bus.Busy_o) bok = 1'b0;
            if (bus.Done_o) begin
                l = i;
                r = bus.Result_o;
                break;
            end
            if (i == poke) begin
                bus.Start_i = 1'b1;
                bus.Funct3_i = 3'b100;
                bus.Operand_a_i = 32'd1;
                bus.Operand_b_i = 32'd1;
            end
        end
        @(posedge clk);
        #1;
        check("done_pulse_ends", {63'b0, bus.Done_o}, 64'd0);
        check("busy_falls", {63'b0, bus.Busy_o}, 64'd0);
    endtask
    initial begin
        bus.Start_i = 1'b0;
        bus.Flush_i = 1'b0;
        bus.Funct3_i = '0;
        bus.Operand_a_i = '0;
        bus.Operand_b_i = '0;
        #1;
        check("reset_busy", {63'b0, bus.Busy_o}, 64'd0);
        check("reset_done", {63'b0, bus.Done_o}, 64'd0);
        check("reset_result", {32'b0, bus.Result_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 10, res, lat, busy_ok);
        check("mul_result", {32'b0, res}, 64'hFFFFFFEB);
        check("mul_latency", 64'(lat), 64'd33);
        check("mul_busy", {63'b0, busy_ok}, 64'd1);
        run_op(3'b001, 32'h80000000, 32'h80000000, -1, res, lat, busy_ok);
        check("mulh", {32'b0, res}, 64'h40000000);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, res, lat, busy_ok);
        check("mulhsu", {32'b0, res}, 64'hFFFFFFFF);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, res, lat, busy_ok);
        check("mulhu", {32'b0, res}, 64'hFFFFFFFE);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, -1, res, lat, busy_ok);
        check("div", {32'b0, res}, 64'hFFFFFFFD);
        check("div_latency", 64'(lat), 64'd33);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, -1, res, lat, busy_ok);
        check("rem", {32'b0, res}, 64'hFFFFFFFF);
        run_op(3'b101, 32'd100, 32'd7, -1, res, lat, busy_ok);
        check("divu", {32'b0, res}, 64'd14);
        run_op(3'b111, 32'd100, 32'd7, -1, res, lat, busy_ok);
        check("remu", {32'b0, res}, 64'd2);
        @(negedge clk);
        bus.Start_i = 1'b1;
        bus.Funct3_i = 3'b100;
        bus.Operand_a_i = 32'd1000;
        bus.Operand_b_i = 32'd3;
        @(posedge clk);
        #1 bus.Start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.Flush_i = 1'b1;
        @(posedge clk);
        #1 bus.Flush_i = 1'b0;
        check("flush_busy", {63'b0, bus.Busy_o}, 64'd0);
        check("flush_done", {63'b0, bus.Done_o}, 64'd0);
        check("flush_result", {32'b0, bus.Result_o}, 64'd2);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.Done_o) seen = 1'b1;
        end
        check("flush_no_done", {63'b0, seen}, 64'd0);
        run_op(3'b000, 32'd3, 32'd4, -1, res, lat, busy_ok);
        check("mul_after_flush", {32'b0, res}, 64'd12);
        @(negedge clk);
        bus.Start_i = 1'b1;
        bus.Funct3_i = 3'b000;
        bus.Operand_a_i = 32'd5;
        bus.Operand_b_i = 32'd6;
        @(posedge clk);
        #1 bus.Start_i = 1'b0;
        repeat (19) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_busy", {63'b0, bus.Busy_o}, 64'd0);
        check("rst_done", {63'b0, bus.Done_o}, 64'd0);
        check("rst_result", {32'b0, bus.Result_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op(3'b011, 32'hFFFFFFFF, 32'd2, -1, res, lat, busy_ok);
        check("mulhu_after_rst", {32'b0, res}, 64'd1);
        run_op(3'b101, 32'd5, 32'd0, -1, res, lat, busy_ok);
        check("divu_by_zero", {32'b0, res}, 64'hFFFFFFFF);
        check("divu_by_zero_lat", 64'(lat), 64'd0);
        check("divu_by_zero_busy", {63'b0, busy_ok}, 64'd1);
        run_op(3'b110, 32'd5, 32'd0, -1, res, lat, busy_ok);
        check("rem_by_zero", {32'b0, res}, 64'd5);
        check("rem_by_zero_lat", 64'(lat), 64'd0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, -1, res, lat, busy_ok);
        check("div_ovf", {32'b0, res}, 64'h80000000);
        check("div_ovf_lat", 64'(lat), 64'd0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, -1, res, lat, busy_ok);
        check("rem_ovf", {32'b0, res}, 64'd0);
        check("rem_ovf_lat", 64'(lat), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
